// File: rtl/pong_pkg.sv
// Shared widths and the sprite descriptor used by the game logic
// and the compositor.
package pong_pkg;

    localparam int PONG_X_W    = 10;
    localparam int PONG_Y_W    = 10;
    localparam int PONG_SIZE_W = 7;
    localparam int PONG_RGB_W  = 12;

    // Callers pack one of these per sprite and slice it onto the
    // compositor's flat per-field arrays.
    typedef struct packed {
        logic                   en;
        logic [PONG_X_W-1:0]    x;
        logic [PONG_Y_W-1:0]    y;
        logic [PONG_SIZE_W-1:0] w;
        logic [PONG_SIZE_W-1:0] h;
        logic [PONG_RGB_W-1:0]  rgb;
    } sprite_t;

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel-stream bundle between the timing generator (master) and the
// compositor (slave): coordinates and syncs in, delayed syncs and colour out.
interface sprite_compositor_if
    import pong_pkg::*;
#(
    parameter int X_W   = PONG_X_W,
    parameter int Y_W   = PONG_Y_W,
    parameter int RGB_W = PONG_RGB_W
);
    logic [X_W-1:0]   pixel_x;
    logic [Y_W-1:0]   pixel_y;
    logic             visible;
    logic             hsync;
    logic             vsync;
    logic             vga_hs;
    logic             vga_vs;
    logic [RGB_W-1:0] vga_rgb;

    modport master (
        output pixel_x, pixel_y, visible, hsync, vsync,
        input  vga_hs, vga_vs, vga_rgb
    );

    modport slave (
        input  pixel_x, pixel_y, visible, hsync, vsync,
        output vga_hs, vga_vs, vga_rgb
    );

endinterface

// File: rtl/sprite_hit.sv
// Combinational point-in-rectangle test for a single sprite. Right and
// bottom edges are summed one bit wider so oversized sprites clip.
module sprite_hit
    import pong_pkg::*;
#(
    parameter int X_W    = PONG_X_W,
    parameter int Y_W    = PONG_Y_W,
    parameter int SIZE_W = PONG_SIZE_W
) (
    input  logic              en_i,
    input  logic [X_W-1:0]    px_i,
    input  logic [Y_W-1:0]    py_i,
    input  logic [X_W-1:0]    sx_i,
    input  logic [Y_W-1:0]    sy_i,
    input  logic [SIZE_W-1:0] w_i,
    input  logic [SIZE_W-1:0] h_i,
    output logic              hit_o
);

    logic [X_W:0] x_end;
    logic [Y_W:0] y_end;

    assign x_end = {1'b0, sx_i} + (X_W+1)'(w_i);
    assign y_end = {1'b0, sy_i} + (Y_W+1)'(h_i);

    // A zero width or height makes the half-open range empty.
    assign hit_o = en_i
                && (px_i >= sx_i) && ({1'b0, px_i} < x_end)
                && (py_i >= sy_i) && ({1'b0, py_i} < y_end);

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: stage 1 registers hit tests and colour
// candidates, stage 2 resolves the final pixel and per-frame collisions.
module sprite_compositor
    import pong_pkg::*;
#(
    parameter int NUM_SPRITES = 3,
    parameter int X_W         = PONG_X_W,
    parameter int Y_W         = PONG_Y_W,
    parameter int SIZE_W      = PONG_SIZE_W,
    parameter int RGB_W       = PONG_RGB_W,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int SEP_EN      = 1,
    parameter int SEP_W       = 4,
    parameter int SEP_PERIOD  = 32,
    parameter int SEP_DOT_H   = 16,
    parameter int SEP_PHASE   = 9
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [X_W-1:0]                     pixel_x_i,
    input  logic [Y_W-1:0]                     pixel_y_i,
    input  logic                               visible_i,
    input  logic                               hsync_i,
    input  logic                               vsync_i,
    input  logic [NUM_SPRITES-1:0]             sprite_en_i,
    input  logic [NUM_SPRITES-1:0][X_W-1:0]    sprite_x_i,
    input  logic [NUM_SPRITES-1:0][Y_W-1:0]    sprite_y_i,
    input  logic [NUM_SPRITES-1:0][SIZE_W-1:0] sprite_w_i,
    input  logic [NUM_SPRITES-1:0][SIZE_W-1:0] sprite_h_i,
    input  logic [NUM_SPRITES-1:0][RGB_W-1:0]  sprite_rgb_i,
    input  logic [RGB_W-1:0]                   bg_rgb_i,
    output logic                               vga_hs_o,
    output logic                               vga_vs_o,
    output logic [RGB_W-1:0]                   vga_rgb_o,
    output logic [NUM_SPRITES-1:0]             collision_o,
    output logic                               frame_done_o
);

    localparam int SEP_LO   = H_RES/2 - SEP_W/2;
    localparam int SEP_HI   = H_RES/2 + SEP_W/2;
    localparam int PER_BITS = $clog2(SEP_PERIOD);

    // ---------------- stage 1: combinational inputs ----------------
    logic [NUM_SPRITES-1:0] hit_d;
    logic [RGB_W-1:0]       base_rgb_d;
    logic                   sep_d;
    logic                   frame_end_d;
    logic [Y_W:0]           sep_line;
    logic [PER_BITS-1:0]    sep_mod;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit #(
            .X_W    (X_W),
            .Y_W    (Y_W),
            .SIZE_W (SIZE_W)
        ) u_hit (
            .en_i  (sprite_en_i[g]),
            .px_i  (pixel_x_i),
            .py_i  (pixel_y_i),
            .sx_i  (sprite_x_i[g]),
            .sy_i  (sprite_y_i[g]),
            .w_i   (sprite_w_i[g]),
            .h_i   (sprite_h_i[g]),
            .hit_o (hit_d[g])
        );
    end

    // Walking down from the top index leaves the lowest hit index as winner.
    always_comb begin
        base_rgb_d = bg_rgb_i;
        for (int i = NUM_SPRITES-1; i >= 0; i--) begin
            if (hit_d[i]) begin
                base_rgb_d = sprite_rgb_i[i];
            end
        end
    end

    // The dash period is a power of two, so the modulo is a bit slice.
    assign sep_line = {1'b0, pixel_y_i} + (Y_W+1)'(SEP_PHASE);
    assign sep_mod  = sep_line[PER_BITS-1:0];
    assign sep_d    = (SEP_EN != 0)
                   && (32'(pixel_x_i) > SEP_LO)
                   && (32'(pixel_x_i) < SEP_HI)
                   && (32'(sep_mod) < SEP_DOT_H);

    assign frame_end_d = (pixel_x_i == '0) && (32'(pixel_y_i) == V_RES);

    // ---------------- stage 1 registers ----------------
    logic [NUM_SPRITES-1:0] hit_q;
    logic [RGB_W-1:0]       base_rgb_q;
    logic                   vis_q;
    logic                   sep_q;
    logic                   frame_end_q;
    logic                   hs1_q;
    logic                   vs1_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_q       <= '0;
            base_rgb_q  <= '0;
            vis_q       <= 1'b0;
            sep_q       <= 1'b0;
            frame_end_q <= 1'b0;
            hs1_q       <= 1'b0;
            vs1_q       <= 1'b0;
        end else begin
            hit_q       <= hit_d;
            base_rgb_q  <= base_rgb_d;
            vis_q       <= visible_i;
            sep_q       <= sep_d;
            frame_end_q <= frame_end_d;
            hs1_q       <= hsync_i;
            vs1_q       <= vsync_i;
        end
    end

    // ---------------- stage 2 ----------------
    logic                   multi_hit;
    logic [NUM_SPRITES-1:0] qual_hits;
    logic [RGB_W-1:0]       rgb_d;

    // Clearing the lowest set bit leaves something only if two or more hit.
    assign multi_hit = (hit_q & (hit_q - NUM_SPRITES'(1))) != '0;
    assign qual_hits = (vis_q && multi_hit) ? hit_q : '0;

    always_comb begin
        rgb_d = base_rgb_q;
        if (!vis_q) begin
            rgb_d = '0;
        end else if (sep_q) begin
            rgb_d = '1;
        end
    end

    logic [RGB_W-1:0]       vga_rgb_q;
    logic                   vga_hs_q;
    logic                   vga_vs_q;
    logic [NUM_SPRITES-1:0] acc_q;
    logic [NUM_SPRITES-1:0] collision_q;
    logic                   frame_done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vga_rgb_q    <= '0;
            vga_hs_q     <= 1'b0;
            vga_vs_q     <= 1'b0;
            acc_q        <= '0;
            collision_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            vga_rgb_q    <= rgb_d;
            vga_hs_q     <= hs1_q;
            vga_vs_q     <= vs1_q;
            frame_done_q <= frame_end_q;
            if (frame_end_q) begin
                collision_q <= acc_q | qual_hits;
                acc_q       <= '0;
            end else begin
                acc_q       <= acc_q | qual_hits;
            end
        end
    end

    assign vga_rgb_o    = vga_rgb_q;
    assign vga_hs_o     = vga_hs_q;
    assign vga_vs_o     = vga_vs_q;
    assign collision_o  = collision_q;
    assign frame_done_o = frame_done_q;

endmodule
